// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch controller: FSM state encoding and PC-mux select codes.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fsm_state_t;

  localparam logic [1:0] SEL_RESET  = 2'd0;
  localparam logic [1:0] SEL_EXT    = 2'd1;
  localparam logic [1:0] SEL_BRANCH = 2'd2;
  localparam logic [1:0] SEL_SEQ    = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) value <= '0;
    else if (inc) value <= sat_inc(value);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: Mealy FSM driving PC load/select and decode flush.
// Optional performance counters are built with FETCH_CTRL_PERF_EN defined.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int PERF_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic              ext_jump,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_load,
  output logic [1:0]        mux_pc_branch_select,
  output logic              flush,
  output logic [1:0]        fsm_state
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_redirect_cnt
`endif
);

  fsm_state_t state_q;
  fsm_state_t state_d;

  // Outputs depend on the current inputs so a redirect lands on the very next edge.
  always_comb begin
    pc_load              = 1'b0;
    mux_pc_branch_select = SEL_SEQ;
    flush                = 1'b0;
    state_d              = state_q;
    if (reset) begin
      pc_load              = 1'b1;
      mux_pc_branch_select = SEL_RESET;
      flush                = 1'b1;
      state_d              = BOOT;
    end else begin
      case (state_q)
        BOOT: begin
          pc_load              = 1'b1;
          mux_pc_branch_select = SEL_RESET;
          flush                = 1'b1;
          state_d              = RUN;
        end
        RUN: begin
          if (ext_jump) begin
            pc_load              = 1'b1;
            mux_pc_branch_select = SEL_EXT;
            flush                = 1'b1;
          end else if (branch_taken) begin
            pc_load              = 1'b1;
            mux_pc_branch_select = SEL_BRANCH;
            flush                = 1'b1;
          end else if (halt_req) begin
            state_d = HALT;
          end else if (!stall) begin
            pc_load = 1'b1;
          end
        end
        HALT: begin
          if (ext_jump) begin
            pc_load              = 1'b1;
            mux_pc_branch_select = SEL_EXT;
            flush                = 1'b1;
            state_d              = RUN;
          end else if (resume) begin
            state_d = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= BOOT;
    else state_q <= state_d;
  end

  assign fsm_state = state_q;

`ifdef FETCH_CTRL_PERF_EN
  logic stall_inc;
  logic redirect_inc;

  // A stall only counts when nothing of higher priority took the cycle.
  assign stall_inc    = !reset && (state_q == RUN) && stall &&
                        !ext_jump && !branch_taken && !halt_req;
  assign redirect_inc = !reset && flush && (state_q != BOOT);

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc),
    .value (perf_stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_redirect_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (redirect_inc),
    .value (perf_redirect_cnt)
  );
`else
  if (PERF_W < 8 || PERF_W > 32) begin : g_perf_w_range
    $error("fetch_ctrl: PERF_W out of range 8..32");
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; counter checks apply when FETCH_CTRL_PERF_EN is defined.
module tb_fetch_ctrl;

  localparam int PERF_W = 8;

  logic clock = 1'b0;
  logic reset, stall, branch_taken, ext_jump, halt_req, resume;
  logic pc_load, flush;
  logic [1:0] mux_pc_branch_select, fsm_state;
`ifdef FETCH_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_stall_cnt, perf_redirect_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  fetch_ctrl #(.PERF_W(PERF_W)) dut (
    .clock                (clock),
    .reset                (reset),
    .stall                (stall),
    .branch_taken         (branch_taken),
    .ext_jump             (ext_jump),
    .halt_req             (halt_req),
    .resume               (resume),
    .pc_load              (pc_load),
    .mux_pc_branch_select (mux_pc_branch_select),
    .flush                (flush),
    .fsm_state            (fsm_state)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_cnt       (perf_stall_cnt),
    .perf_redirect_cnt    (perf_redirect_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the Mealy outputs and state for the current cycle.
  task automatic chk_out(input string tag, input logic ld, input logic [1:0] sel,
                         input logic fl, input logic [1:0] st);
    chk({tag, ".load"},  {31'd0, pc_load}, {31'd0, ld});
    chk({tag, ".sel"},   {30'd0, mux_pc_branch_select}, {30'd0, sel});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, fl});
    chk({tag, ".state"}, {30'd0, fsm_state}, {30'd0, st});
  endtask

  task automatic chk_cnt(input string tag, input int stall_exp, input int redir_exp);
`ifdef FETCH_CTRL_PERF_EN
    chk({tag, ".stall_cnt"}, 32'(perf_stall_cnt), 32'(stall_exp));
    chk({tag, ".redirect_cnt"}, 32'(perf_redirect_cnt), 32'(redir_exp));
`else
    if (stall_exp < 0 || redir_exp < 0) $display("note: %s", tag);
`endif
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clock);
    #1;
  endtask

  task automatic clr_in();
    stall = 0; branch_taken = 0; ext_jump = 0; halt_req = 0; resume = 0;
  endtask

  initial begin
    reset = 1'b1;
    clr_in();

    // Reset held three cycles
    next_cycle();
    chk({"rst0", ".load"},  {31'd0, pc_load}, 32'd1);
    chk({"rst0", ".sel"},   {30'd0, mux_pc_branch_select}, 32'd0);
    chk({"rst0", ".flush"}, {31'd0, flush}, 32'd1);
    next_cycle(); chk_out("rst1", 1, 2'd0, 1, 2'd0); chk_cnt("rst1", 0, 0);
    next_cycle(); chk_out("rst2", 1, 2'd0, 1, 2'd0);
    reset = 1'b0; #1;
    chk_out("boot", 1, 2'd0, 1, 2'd0);
    next_cycle(); chk_out("run0", 1, 2'd3, 0, 2'd1);

    // Four stall cycles
    stall = 1; #1;
    for (int i = 0; i < 4; i++) begin
      chk_out("stall", 0, 2'd3, 0, 2'd1);
      next_cycle();
    end
    stall = 0; #1;
    chk_out("post_stall", 1, 2'd3, 0, 2'd1);
    chk_cnt("post_stall", 4, 0);

    // Branch overrides stall
    next_cycle();
    stall = 1; branch_taken = 1; #1;
    chk_out("br_stall", 1, 2'd2, 1, 2'd1);
    next_cycle(); clr_in(); #1;
    chk_cnt("br_stall", 4, 1);

    // ext_jump beats branch
    ext_jump = 1; branch_taken = 1; #1;
    chk_out("ext_br", 1, 2'd1, 1, 2'd1);
    next_cycle(); clr_in(); #1;
    chk_out("after_ext", 1, 2'd3, 0, 2'd1);
    chk_cnt("after_ext", 4, 2);

    // halt pulse, five halted cycles (with ignored inputs), then resume
    halt_req = 1; #1;
    chk_out("halt_req", 0, 2'd3, 0, 2'd1);
    next_cycle(); clr_in(); #1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin stall = 1; branch_taken = 1; halt_req = 1; #1; end
      chk_out("halted", 0, 2'd3, 0, 2'd2);
      next_cycle(); clr_in(); #1;
    end
    resume = 1; #1;
    chk_out("resume", 0, 2'd3, 0, 2'd2);
    next_cycle(); clr_in(); #1;
    chk_out("resumed", 1, 2'd3, 0, 2'd1);
    chk_cnt("resumed", 4, 2);

    // HALT with ext_jump and resume together
    halt_req = 1;
    next_cycle(); clr_in();
    ext_jump = 1; resume = 1; #1;
    chk_out("halt_ext", 1, 2'd1, 1, 2'd2);
    next_cycle(); clr_in(); #1;
    chk_out("halt_ext_run", 1, 2'd3, 0, 2'd1);
    chk_cnt("halt_ext_run", 4, 3);

    // Reset mid-redirect overrides ext_jump
    ext_jump = 1; reset = 1; #1;
    chk_out("rst_redir", 1, 2'd0, 1, 2'd1);
    next_cycle(); clr_in(); reset = 0; #1;
    chk_out("rst_redir_boot", 1, 2'd0, 1, 2'd0);
    chk_cnt("rst_redir_boot", 0, 0);
    next_cycle(); chk_out("rst_redir_run", 1, 2'd3, 0, 2'd1);

    // Saturation after 300 stall cycles with PERF_W=8
    stall = 1;
    for (int i = 0; i < 300; i++) next_cycle();
    stall = 0; #1;
    chk_cnt("sat", 255, 0);
    chk_out("sat_run", 1, 2'd3, 0, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PERF_W, default 16: width of the performance counters; legal range 8..32.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  downstream cannot accept a new instruction this cycle.
REQ-005 branch_taken  input  1  resolved taken branch; the target is on the PC mux branch input this cycle.
REQ-006 ext_jump  input  1  external/debug jump; the address is on the PC mux external input this cycle.
REQ-007 halt_req  input  1  request to freeze fetch.
REQ-008 resume  input  1  leave the halted state.
REQ-009 pc_load  output  1  load enable for the program counter.
REQ-010 mux_pc_branch_select  output  2  PC source: 0 = reset vector 0x0000, 1 = external address, 2 = branch target, 3 = sequential PC+1.
REQ-011 flush  output  1  kill the instruction currently in decode.
REQ-012 fsm_state  output  2  current state: 0 = BOOT, 1 = RUN, 2 = HALT.
REQ-013 perf_stall_cnt, perf_redirect_cnt  output  PERF_W each  present only with FETCH_CTRL_PERF_EN.

Function
REQ-014 The state register SHALL be registered; pc_load, mux_pc_branch_select and flush SHALL be combinational from the state and the current inputs (Mealy), so a PC update lands on the next clock edge.
REQ-015 BOOT: select=0, pc_load=1, flush=1 for exactly one cycle, then RUN unconditionally; all inputs ignored.
REQ-016 RUN input priority SHALL be ext_jump > branch_taken > halt_req > stall > sequential.
REQ-017 RUN + ext_jump: select=1, pc_load=1, flush=1; stay in RUN.
REQ-018 RUN + branch_taken (no ext_jump): select=2, pc_load=1, flush=1; stay in RUN; the redirect overrides a simultaneous stall.
REQ-019 RUN + halt_req (no redirect): pc_load=0, flush=0; go to HALT next cycle.
REQ-020 RUN + stall only: pc_load=0, select=3, flush=0; the PC holds.
REQ-021 RUN with no request: pc_load=1, select=3, flush=0.
REQ-022 HALT: pc_load=0, select=3, flush=0; resume goes to RUN next cycle.
REQ-023 HALT + ext_jump: select=1, pc_load=1, flush=1; go to RUN; this has priority over resume.
REQ-024 HALT ignores stall, branch_taken and halt_req.
REQ-025 When not driven by another rule, select SHALL be 3; the unused state encoding 3 SHALL return to BOOT on the next cycle.

Reset
REQ-026 Reset SHALL force BOOT on the next edge and override every input, including mid-redirect and in HALT.
REQ-027 While reset is asserted, outputs SHALL be pc_load=1, select=0, flush=1, and any enabled counters SHALL clear to 0.
REQ-028 After reset deasserts, the first cycle SHALL be BOOT per REQ-015.

Configuration
REQ-029 With FETCH_CTRL_PERF_EN defined:
- perf_stall_cnt SHALL increment on each RUN cycle that applies REQ-020.
- perf_redirect_cnt SHALL increment on each cycle with flush=1 outside BOOT and reset.
- Both counters SHALL saturate at 2^PERF_W-1.
REQ-030 Without FETCH_CTRL_PERF_EN, the counter ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 A shared package SHALL hold:
- the fsm_state enum (BOOT/RUN/HALT);
- the PC-select constants SEL_RESET=0, SEL_EXT=1, SEL_BRANCH=2, SEL_SEQ=3.
REQ-032 One sub-module, sat_counter (parameter W; ports clock, reset, inc, value), SHALL be instantiated twice under FETCH_CTRL_PERF_EN.

Verification
REQ-033 Reset 3 cycles, then release -> during reset: load=1, sel=0, flush=1; first post-reset cycle BOOT with the same values; second cycle RUN with load=1, sel=3.
REQ-034 RUN, stall=1 for 4 cycles -> load=0, sel=3 each cycle; perf_stall_cnt=4.
REQ-035 RUN, stall=1 and branch_taken=1 together -> load=1, sel=2, flush=1; perf_redirect_cnt=1.
REQ-036 ext_jump=1 and branch_taken=1 together -> sel=1, load=1, flush=1.
REQ-037 halt_req pulse, wait 5 cycles, then resume -> state 2 from the next cycle with load=0 throughout; state 1 the cycle after resume.
REQ-038 In HALT, ext_jump and resume together -> sel=1, load=1, flush=1; state 1 the next cycle. With PERF_W=8, 300 stall cycles -> perf_stall_cnt=255.
